// File: rtl/serial_parity_checker_if.sv
// Bit-level input and word-level result bundle for serial_parity_checker.
// err_count exists only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              bit_valid;
    logic              din;
    logic              odd;
    logic [DATA_W-1:0] dout;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0]        err_count;

    modport master (
        output bit_valid, din, odd,
        input  dout, data_valid, parity_err, frame_err, err_count
    );
    modport slave (
        input  bit_valid, din, odd,
        output dout, data_valid, parity_err, frame_err, err_count
    );
`else
    modport master (
        output bit_valid, din, odd,
        input  dout, data_valid, parity_err, frame_err
    );
    modport slave (
        input  bit_valid, din, odd,
        output dout, data_valid, parity_err, frame_err
    );
`endif
endinterface

// File: rtl/serial_parity_checker.sv
// Serial deframer: start, DATA_W data bits LSB first, parity, stop.
// Define PARITY_ERR_CNT_EN to add the saturating err_count output.
module serial_parity_checker #(
    parameter int DATA_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    serial_parity_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;
    localparam logic [5:0] LAST   = 6'(DATA_W - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              acc_q, acc_d;
    logic              odd_q, odd_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              pe_q, pe_d;
    logic              fe_q, fe_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        odd_d   = odd_q;
        perr_d  = perr_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        pe_d    = pe_q;
        fe_d    = fe_q;
        if (bus.bit_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.din) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                        odd_d   = bus.odd;
                    end
                end
                S_DATA: begin
                    // right shift: first bit received ends up in bit 0
                    sh_d  = (sh_q >> 1)
                          | (DATA_W'(bus.din) << (DATA_W - 1));
                    acc_d = acc_q ^ bus.din;
                    if (cnt_q == LAST) begin
                        state_d = S_PAR;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_PAR: begin
                    perr_d  = acc_q ^ bus.din ^ odd_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    dout_d  = sh_q;
                    pe_d    = perr_q;
                    fe_d    = ~bus.din;
                    dv_d    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= 1'b0;
            odd_q   <= 1'b0;
            perr_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            odd_q   <= odd_d;
            perr_q  <= perr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    // one increment per bad frame, held at 255
    always_comb begin
        ecnt_d = ecnt_q;
        if (dv_d && (pe_d || fe_d) && (ecnt_q != 8'hFF)) begin
            ecnt_d = ecnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign bus.err_count = ecnt_q;
`endif
endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed table-driven bench for serial_parity_checker (DATA_W = 8).
// Exercises PARITY_ERR_CNT_EN checks when that macro is defined.
module tb_serial_parity_checker;
    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic       oddmid;
        logic       par;
        logic       stop;
        logic       eperr;
        logic       eferr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   dv_cnt;
    int   exp_cnt;
    vec_t tbl[10];

    serial_parity_checker_if #(.DATA_W(8)) bus ();

    serial_parity_checker #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.data_valid === 1'b1) dv_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int gmax);
        int g;
        g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
        repeat (g) begin
            bus.bit_valid = 1'b0;
            bus.din = 1'($urandom);
            @(negedge clk);
        end
        bus.bit_valid = 1'b1;
        bus.din = b;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        bus.din = 1'b1;
    endtask

    task automatic frame(input vec_t v, input int gmax, input string tag);
        int d0;
        d0 = dv_cnt;
        bus.odd = v.odd;
        drive(1'b0, gmax);
        bus.odd = v.oddmid;
        for (int i = 0; i < 8; i++) drive(v.data[i], gmax);
        drive(v.par, gmax);
        drive(v.stop, gmax);
        if (v.eperr || v.eferr) begin
            if (exp_cnt < 255) exp_cnt++;
        end
        chk({tag, " data_valid"}, 32'(bus.data_valid), 32'd1);
        chk({tag, " dout"}, 32'(bus.dout), 32'(v.data));
        chk({tag, " parity_err"}, 32'(bus.parity_err), 32'(v.eperr));
        chk({tag, " frame_err"}, 32'(bus.frame_err), 32'(v.eferr));
        chk({tag, " pulses"}, 32'(dv_cnt - d0), 32'd1);
`ifdef PARITY_ERR_CNT_EN
        chk({tag, " err_count"}, 32'(bus.err_count), 32'(exp_cnt));
`endif
    endtask

    initial begin
        int d0;
        checks  = 0;
        errors  = 0;
        dv_cnt  = 0;
        exp_cnt = 0;
        //          data   odd  mid  par  stop perr ferr
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        bus.bit_valid = 1'b0;
        bus.din = 1'b1;
        bus.odd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dout", 32'(bus.dout), 32'd0);
        chk("reset data_valid", 32'(bus.data_valid), 32'd0);
        chk("reset parity_err", 32'(bus.parity_err), 32'd0);
        chk("reset frame_err", 32'(bus.frame_err), 32'd0);
`ifdef PARITY_ERR_CNT_EN
        chk("reset err_count", 32'(bus.err_count), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // back-to-back, no gaps
        for (int i = 0; i < 10; i++) frame(tbl[i], 0, $sformatf("v%0d", i));
        @(negedge clk);
        chk("single cycle pulse", 32'(bus.data_valid), 32'd0);
        chk("hold dout", 32'(bus.dout), 32'hFF);

        for (int i = 0; i < 10; i++) frame(tbl[i], 5, $sformatf("gap%0d", i));

        // abort mid-frame with reset
        d0 = dv_cnt;
        bus.odd = 1'b0;
        drive(1'b0, 0);
        drive(1'b0, 0);
        drive(1'b1, 0);
        drive(1'b0, 0);
        drive(1'b1, 0);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("abort dout", 32'(bus.dout), 32'd0);
        chk("abort data_valid", 32'(bus.data_valid), 32'd0);
        chk("abort parity_err", 32'(bus.parity_err), 32'd0);
        chk("abort frame_err", 32'(bus.frame_err), 32'd0);
`ifdef PARITY_ERR_CNT_EN
        chk("abort err_count", 32'(bus.err_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort no pulse", 32'(dv_cnt - d0), 32'd0);
        frame(tbl[0], 0, "after_abort");
        frame(tbl[9], 2, "after_abort2");

`ifdef PARITY_ERR_CNT_EN
        for (int i = 0; i < 260; i++) frame(tbl[1], 0, $sformatf("sat%0d", i));
        chk("saturated err_count", 32'(bus.err_count), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side counterpart to the team's even/odd parity generator. Deframes a serial bitstream (start bit, DATA_W data bits LSB first, one parity bit, stop bit) and recovers the data word. Checks parity in the selected even or odd mode and reports parity and framing errors. Sits between the serial line sampler, which supplies one qualified bit per `bit_valid`, and the word-level consumer.

## Interface
- `DATA_W`, default 8, number of data bits per frame (legal range 1–32).

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `bit_valid`  input  1  `din` holds a valid line bit this cycle
- `din`  input  1  serial line bit; idles high
- `odd`  input  1  parity mode: 0 = even, 1 = odd; sampled on the start bit
- `dout`  output  DATA_W  last received data word
- `data_valid`  output  1  one-cycle pulse when a frame completes
- `parity_err`  output  1  parity error flag of last frame; valid with `data_valid`
- `frame_err`  output  1  stop-bit error flag of last frame; valid with `data_valid`
- `err_count`  output  8  saturating error count; present only with `PARITY_ERR_CNT_EN`

## Operation
- Reset values: FSM = IDLE; `dout` = 0; `data_valid` = 0; `parity_err` = 0; `frame_err` = 0; `err_count` = 0. Bit counter, shift register and accumulator are also cleared.
- The FSM advances only on cycles with `bit_valid` = 1. Cycles with `bit_valid` = 0 hold all state, and any number of gap cycles is legal.
- **IDLE**
  - `din` = 1: remain in IDLE.
  - `din` = 0 (start bit): go to DATA, clear the bit counter and the parity accumulator, and latch `odd` into `odd_q`.
- **DATA**
  - Each bit shifts into the MSB of the shift register (right-shift), so the first bit received lands in bit 0.
  - Each bit updates the accumulator: `acc ^= din`.
  - After DATA_W bits, go to PARITY.
- **PARITY**
  - Compute `perr_q = acc ^ din ^ odd_q`. Even mode requires an even total count of ones across data and parity; odd mode requires an odd total.
  - Go to STOP.
- **STOP**
  - Compute `ferr = ~din`.
  - On the next edge, load `dout` = shift register, `parity_err` = `perr_q`, `frame_err` = `ferr`, and pulse `data_valid`.
  - Return to IDLE regardless of the stop value; no break detection.
- `dout`, `parity_err` and `frame_err` hold until the next frame completes. Consumers must sample them with `data_valid`.
- The FSM does not change `odd_q` between the start bit and the stop bit; changes to `odd` mid-frame have no effect.
- Asserting `rst_n` mid-frame aborts the frame with no `data_valid` pulse, and all outputs return to their reset values.

## Timing
- `data_valid` rises on the clock edge at which the stop bit is sampled, so it is visible the cycle after the stop-bit `bit_valid`. It stays high for exactly one cycle.
- Minimum frame length is DATA_W + 3 `bit_valid` cycles.
- Back-to-back frames: a start bit may arrive on the first `bit_valid` after the stop bit. This start bit can coincide with the `data_valid` cycle, and both are handled in that cycle.
- All outputs are registered, with no combinational path from the inputs to the outputs.

## Configuration
- `PARITY_ERR_CNT_EN` defined:
  - `err_count` port exists.
  - It increments by 1 on each `data_valid` where `parity_err | frame_err` = 1, with one increment per frame even when both errors occur.
  - It saturates at 255 and clears only on reset.
- `PARITY_ERR_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Even, good frame:** DATA_W=8, `odd`=0, stream 0, 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1 -> `dout`=0xA5, single-cycle `data_valid`, `parity_err`=0, `frame_err`=0.
- **Even, bad parity:** same frame with parity bit 1 -> `dout`=0xA5, `parity_err`=1, `frame_err`=0. `err_count`=1 if enabled.
- **Odd mode and mid-frame `odd` change:**
  - `odd`=1 on the start bit, data 0x01, parity 0 -> `parity_err`=0.
  - Toggle `odd` to 0 during the data bits -> still `parity_err`=0.
- **Framing error, then back-to-back:**
  - Stop bit 0 -> `frame_err`=1.
  - A start bit arriving on the next `bit_valid` is accepted, and the following good frame reports `frame_err`=0.
- **Gaps and reset:**
  - Random 0–5 cycle `bit_valid` gaps between bits -> results identical to the gapless case.
  - `rst_n` pulsed low after 4 data bits -> no `data_valid`, outputs at reset values, and the next full frame decodes correctly.
- **Counter saturation (macro on):** 260 frames with bad parity -> `err_count` stops at 255.
